seg7_scan_driver: RTL and testbench

Time-multiplexed 4-digit hexadecimal seven-segment driver that sits directly downstream of the 16-bit up/down counter. It consumes the counter's `count` bus and scans one digit per refresh slot. It latches a tear-free snapshot at each frame boundary. It drives active-low anode and segment lines for a common-anode board display.

---
 rtl/seg7_scan_driver.sv | 118 +++++++++++
 tb/tb_seg7_scan_driver.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Four-digit hex seven-segment scanner with a frame-wrap snapshot of count and optional leading-zero blanking.
// Latency: the outputs are registered and lag dig/snap/HOLD by one cycle, so a captured count reaches digit 0 one cycle after the wrap.
// Backpressure: none; the scan runs freely and samples count only at frame wraps.
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] count,
    input  logic        HOLD,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int            PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] presc;
    logic          tick;
    logic [1:0]    dig;
    logic [15:0]   snap;
    logic [3:0]    nib;
    logic          blank;
    logic [3:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        glyph = 7'b1111111;
        case (n)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            4'hF: glyph = 7'b0001110;
        endcase
    endfunction

    assign tick = (presc == PMAX);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dig <= 2'd0;
        end else if (tick) begin
            dig <= dig + 2'd1;
        end
    end

    // Capturing only at the wrap keeps all four digits of one frame from the same count value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            snap <= 16'h0000;
        end else if (tick && (dig == 2'd3) && !HOLD) begin
            snap <= count;
        end
    end

    assign nib = snap[{dig, 2'b00} +: 4];

    always_comb begin
        blank = 1'b0;
        if (BLANK_LZ) begin
            case (dig)
                2'd1:    blank = (snap[15:4]  == 12'h000);
                2'd2:    blank = (snap[15:8]  == 8'h00);
                2'd3:    blank = (snap[15:12] == 4'h0);
                default: blank = 1'b0;
            endcase
        end
    end

    always_comb begin
        an_nxt  = ~(4'b0001 << dig);
        seg_nxt = glyph(nib);
        dp_nxt  = !((dig == 2'd0) && HOLD);
        if (blank) begin
            an_nxt  = 4'b1111;
            seg_nxt = 7'b1111111;
            dp_nxt  = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a plain instance and a leading-zero-blanking instance, both with a four-cycle slot.
module tb_seg7_scan_driver;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GF = 7'b0001110;
    localparam logic [6:0] BL = 7'b1111111;

    localparam int T_RST = 0, T_START = 1, T_SCAN = 2, T_TEAR = 3, T_HOLD = 4, T_BLANK = 5, T_ASYNC = 6, T_RESTART = 7;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] count_a = 16'hABCD;
    logic [15:0] count_b = 16'hABCD;
    logic        hold_a = 1'b0;
    logic        hold_b = 1'b0;
    logic [3:0]  an_a, an_b;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;

    seg7_scan_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_a (
        .CLK(CLK), .RST(RST), .count(count_a), .HOLD(hold_a),
        .an(an_a), .seg(seg_a), .dp(dp_a)
    );

    seg7_scan_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut_b (
        .CLK(CLK), .RST(RST), .count(count_b), .HOLD(hold_b),
        .an(an_b), .seg(seg_b), .dp(dp_b)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         at;
        int         which;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        int         tag;
    } exp_t;

    exp_t sbq[$];
    int   pcnt = 0;
    int   checks = 0;
    int   failures = 0;

    // Expected glyph per displayed frame and slot; BL marks a blanked slot.
    logic [6:0] tab_a [8][4] = '{
        '{G0, G0, G0, G0},
        '{G4, G3, G2, G1},
        '{G4, G3, G2, G1},
        '{GF, GF, GF, GF},
        '{GF, G0, G0, G1},
        '{GF, G0, G0, G1},
        '{GF, G0, G0, G1},
        '{GF, G3, G0, G1}
    };
    logic [6:0] tab_b [8][4] = '{
        '{G0, BL, BL, BL},
        '{G5, BL, BL, BL},
        '{G0, BL, BL, BL},
        '{G0, GA, BL, BL},
        '{G0, G0, G3, BL},
        '{G0, G0, G3, BL},
        '{G0, G0, G3, BL},
        '{G0, G0, G3, BL}
    };
    logic [3:0] onecold [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    always @(posedge CLK) pcnt <= pcnt + 1;

    function automatic string tagname(input int t);
        case (t)
            T_RST:     return "reset_dark";
            T_START:   return "startup";
            T_SCAN:    return "scan";
            T_TEAR:    return "no_tear";
            T_HOLD:    return "hold";
            T_BLANK:   return "blank_lz";
            T_ASYNC:   return "async_reset";
            T_RESTART: return "restart";
            default:   return "unknown";
        endcase
    endfunction

    task automatic push(input int at, input int which, input logic [3:0] a,
                        input logic [6:0] s, input logic d, input int tag);
        exp_t e;
        e.at = at; e.which = which; e.an = a; e.seg = s; e.dp = d; e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic push_slot(input int at, input int which, input int slot,
                             input logic [6:0] s, input logic d, input int tag);
        if (s == BL) push(at, which, 4'b1111, BL, 1'b1, tag);
        else         push(at, which, onecold[slot], s, d, tag);
    endtask

    task automatic push_dark(input int at, input int tag);
        push(at, 0, 4'b1111, BL, 1'b1, tag);
        push(at, 1, 4'b1111, BL, 1'b1, tag);
    endtask

    // Monitor: every falling edge, retire all expectations due at this cycle.
    exp_t       cur;
    logic [3:0] act_an;
    logic [6:0] act_seg;
    logic       act_dp;
    always @(negedge CLK) begin
        while (sbq.size() > 0 && sbq[0].at <= pcnt) begin
            cur = sbq.pop_front();
            checks++;
            act_an  = (cur.which == 0) ? an_a  : an_b;
            act_seg = (cur.which == 0) ? seg_a : seg_b;
            act_dp  = (cur.which == 0) ? dp_a  : dp_b;
            if (cur.at < pcnt) begin
                failures++;
                $display("FAIL %s dut%0d cyc=%0d expectation missed (now %0d)",
                         tagname(cur.tag), cur.which, cur.at, pcnt);
            end else if (act_an !== cur.an || act_seg !== cur.seg || act_dp !== cur.dp) begin
                failures++;
                $display("FAIL %s dut%0d cyc=%0d an=%b exp=%b seg=%b exp=%b dp=%b exp=%b",
                         tagname(cur.tag), cur.which, cur.at, act_an, cur.an,
                         act_seg, cur.seg, act_dp, cur.dp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    int base, rel, f, s, tag;

    initial begin
        // Held in reset for three edges with a nonzero count present.
        for (int i = 1; i <= 3; i++) push_dark(i, T_RST);
        repeat (3) @(negedge CLK);
        base = pcnt;

        for (int k = 1; k <= 120; k++) begin
            rel = k - 1;
            if (rel == 0) begin
                RST     = 1'b0;
                count_a = 16'h1234;
                count_b = 16'h0005;
            end
            if (rel == 20) count_b = 16'h0000;
            if (rel == 37) count_a = 16'hFFFF;
            if (rel == 40) count_b = 16'h00A0;
            if (rel == 56) count_b = 16'h0300;
            if (rel >= 48 && rel <= 111) count_a = 16'h1000 + 16'(rel - 48);
            if (rel == 64)  hold_a = 1'b1;
            if (rel == 108) hold_a = 1'b0;

            f = rel / 16;
            s = (rel / 4) % 4;
            if (f == 0)      tag = T_START;
            else if (f == 1) tag = T_SCAN;
            else if (f <= 3) tag = T_TEAR;
            else             tag = T_HOLD;
            push_slot(base + k, 0, s, tab_a[f][s], (f >= 4 && f <= 6 && s == 0) ? 1'b0 : 1'b1, tag);
            push_slot(base + k, 1, s, tab_b[f][s], 1'b1, T_BLANK);
            @(negedge CLK);
        end

        // Reset lands between edges while digit 2 is on display.
        push_dark(base + 121, T_ASYNC);
        @(posedge CLK);
        #1 RST = 1'b1;
        @(negedge CLK);
        push_dark(base + 122, T_ASYNC);
        @(negedge CLK);
        push_dark(base + 123, T_ASYNC);
        @(negedge CLK);
        RST  = 1'b0;
        base = pcnt;

        for (int k = 1; k <= 17; k++) begin
            s = ((k - 1) / 4) % 4;
            if (k <= 16) begin
                push_slot(base + k, 0, s, tab_a[0][s], 1'b1, T_RESTART);
                push_slot(base + k, 1, s, tab_b[0][s], 1'b1, T_RESTART);
            end else begin
                push(base + k, 0, 4'b1110, GF, 1'b1, T_RESTART);
                push(base + k, 1, 4'b1110, G0, 1'b1, T_RESTART);
            end
            @(negedge CLK);
        end

        repeat (2) @(negedge CLK);
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL leftover pending=%0d required=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
